// File: rtl/shift_seq.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq
// Purpose  : Multi-cycle logical shift sequencer. Breaks a request for a
//            total shift of up to 2^AMT_W-1 positions into steps of 2 or 1
//            positions and drives them to an external combinational 2x4
//            shifter, feeding each result back until the whole amount is done.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            in_valid/in_ready      - request handshake (ready only in IDLE)
//            in_a, in_amt, in_dir   - operand, total amount, 0=left 1=right
//            sh_a, sh_amt, sh_dir   - step command to the external shifter
//            sh_y                   - external shifter result
//            out_valid/out_ready    - result handshake (valid only in DONE)
//            out_y                  - final shifted operand
// Config   : SHIFT_SEQ_ZERO_SKIP_EN - finish early once the operand is 0000
// Revision : 1.0 - initial release
// ============================================================================
module shift_seq #(
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    output logic [3:0]       sh_a,
    output logic [1:0]       sh_amt,
    output logic             sh_dir,
    input  logic [3:0]       sh_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_y
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_STEP = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [3:0]       r_work;
    logic [3:0]       w_work_nxt;
    logic [AMT_W-1:0] r_rem;
    logic [AMT_W-1:0] w_rem_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic [1:0]       w_step;
    logic [AMT_W-1:0] w_rem_dec;
    logic             w_skip_in;
    logic             w_skip_step;

    // Largest legal step is 2; a remainder of 1 takes the final single step.
    assign w_step    = (r_rem >= AMT_W'(2)) ? 2'b10 : 2'b01;
    assign w_rem_dec = r_rem - AMT_W'(w_step);

`ifdef SHIFT_SEQ_ZERO_SKIP_EN
    // Once the operand is all zeros, further shifting cannot change it.
    assign w_skip_in   = (in_a == 4'b0000);
    assign w_skip_step = (sh_y == 4'b0000);
`else
    assign w_skip_in   = 1'b0;
    assign w_skip_step = 1'b0;
`endif

    // Handshakes and outputs decode directly from registered state.
    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign out_y     = r_work;
    assign sh_a      = r_work;
    assign sh_dir    = r_dir;
    assign sh_amt    = (r_state == c_STEP) ? w_step : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_rem_nxt   = r_rem;
        w_dir_nxt   = r_dir;
        case (r_state)
            c_IDLE: begin
                if (in_valid) begin
                    w_work_nxt = in_a;
                    w_rem_nxt  = in_amt;
                    w_dir_nxt  = in_dir;
                    if ((in_amt == '0) || w_skip_in) begin
                        w_state_nxt = c_DONE;
                    end else begin
                        w_state_nxt = c_STEP;
                    end
                end
            end
            c_STEP: begin
                w_work_nxt = sh_y;
                w_rem_nxt  = w_rem_dec;
                if ((w_rem_dec == '0) || w_skip_step) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                // Result stays frozen until the consumer takes it; the
                // return to IDLE costs a cycle so no accept overlaps it.
                if (out_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work <= 4'b0000;
            r_rem  <= '0;
            r_dir  <= 1'b0;
        end else begin
            r_work <= w_work_nxt;
            r_rem  <= w_rem_nxt;
            r_dir  <= w_dir_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_seq
// Purpose  : Directed self-checking bench for shift_seq, including a
//            behavioural model of the downstream 2x4 logical shifter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_seq;

    localparam int AMT_W = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_a;
    logic [AMT_W-1:0] in_amt;
    logic             in_dir;
    logic [3:0]       sh_a;
    logic [1:0]       sh_amt;
    logic             sh_dir;
    logic [3:0]       sh_y;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_y;

    int n_vec  = 0;
    int n_fail = 0;

    shift_seq #(.AMT_W(AMT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_amt   (in_amt),
        .in_dir   (in_dir),
        .sh_a     (sh_a),
        .sh_amt   (sh_amt),
        .sh_dir   (sh_dir),
        .sh_y     (sh_y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y    (out_y)
    );

    // Downstream combinational shifter.
    assign sh_y = sh_dir ? (sh_a >> sh_amt) : (sh_a << sh_amt);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and wait (bounded) for DONE; outputs
    // stay in DONE. steps = -1 if the budget expired. seq collects the
    // sh_amt value of each STEP cycle, oldest in the high bits.
    task automatic do_req(input logic [3:0] a, input logic [AMT_W-1:0] amt,
                          input logic dir, output int steps,
                          output logic [3:0] y, output logic [7:0] seq);
        in_valid = 1'b1;
        in_a     = a;
        in_amt   = amt;
        in_dir   = dir;
        tick();
        in_valid = 1'b0;
        in_a     = ~a;
        in_amt   = '1;
        in_dir   = ~dir;
        steps    = 0;
        seq      = 8'h00;
        while (!out_valid && steps < 20) begin
            seq = {seq[5:0], sh_amt};
            steps++;
            tick();
        end
        if (!out_valid) steps = -1;
        y = out_y;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_a = 4'b1111;
        in_amt = 3'd3;
        in_dir = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({in_ready, out_valid, out_y, sh_amt, sh_a, sh_dir} !== {1'b1, 1'b0, 4'h0, 2'b00, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b y=%b amt=%b a=%b dir=%b, want 1 0 0000 00 0000 0",
                     in_ready, out_valid, out_y, sh_amt, sh_a, sh_dir);
        end
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_amt3_left();
        int s; logic [3:0] y; logic [7:0] q;
        do_req(4'b1011, 3'd3, 1'b0, s, y, q);
        n_vec++;
        if (y !== 4'b1000) begin n_fail++; $display("FAIL amt3_left_y: got %b want 1000", y); end
        n_vec++;
        if (s !== 2) begin n_fail++; $display("FAIL amt3_left_steps: got %0d want 2", s); end
        n_vec++;
        if (q !== 8'b0000_1001) begin n_fail++; $display("FAIL amt3_left_seq: got %b want 00001001", q); end
        consume();
    endtask

    task automatic test_amt5_right();
        int s; logic [3:0] y; logic [7:0] q;
        do_req(4'b1011, 3'd5, 1'b1, s, y, q);
        n_vec++;
        if (y !== 4'b0000) begin n_fail++; $display("FAIL amt5_right_y: got %b want 0000", y); end
`ifdef SHIFT_SEQ_ZERO_SKIP_EN
        n_vec++;
        if (s !== 2) begin n_fail++; $display("FAIL amt5_right_steps: got %0d want 2", s); end
        n_vec++;
        if (q !== 8'b0000_1010) begin n_fail++; $display("FAIL amt5_right_seq: got %b want 00001010", q); end
`else
        n_vec++;
        if (s !== 3) begin n_fail++; $display("FAIL amt5_right_steps: got %0d want 3", s); end
        n_vec++;
        if (q !== 8'b0010_1001) begin n_fail++; $display("FAIL amt5_right_seq: got %b want 00101001", q); end
`endif
        consume();
    endtask

    task automatic test_amt0();
        int s; logic [3:0] y; logic [7:0] q;
        do_req(4'b0110, 3'd0, 1'b0, s, y, q);
        n_vec++;
        if (s !== 0) begin n_fail++; $display("FAIL amt0_steps: got %0d want 0", s); end
        n_vec++;
        if (y !== 4'b0110) begin n_fail++; $display("FAIL amt0_y: got %b want 0110", y); end
        n_vec++;
        if (sh_amt !== 2'b00) begin n_fail++; $display("FAIL amt0_sh_amt: got %b want 00", sh_amt); end
        consume();
    endtask

    task automatic test_hold();
        int s; logic [3:0] y; logic [7:0] q;
        do_req(4'b0001, 3'd2, 1'b0, s, y, q);
        n_vec++;
        if (y !== 4'b0100) begin n_fail++; $display("FAIL hold_y: got %b want 0100", y); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if ({out_valid, out_y, in_ready} !== {1'b1, 4'b0100, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got vld=%b y=%b rdy=%b want 1 0100 0", i, out_valid, out_y, in_ready);
            end
        end
        consume();
        n_vec++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        int s; logic [3:0] y; logic [7:0] q;
        in_valid = 1'b1;
        in_a = 4'b1111;
        in_amt = 3'd7;
        in_dir = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();                 // now in the 2nd STEP cycle
        n_vec++;
        if (sh_amt !== 2'b10) begin n_fail++; $display("FAIL midflight_step2: got sh_amt=%b want 10", sh_amt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({in_ready, out_valid, out_y, sh_amt, sh_a, sh_dir} !== {1'b1, 1'b0, 4'h0, 2'b00, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL midflight_reset: got rdy=%b vld=%b y=%b amt=%b a=%b dir=%b, want 1 0 0000 00 0000 0",
                     in_ready, out_valid, out_y, sh_amt, sh_a, sh_dir);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midflight_noresult: got vld=%b want 0", out_valid); end
        do_req(4'b0001, 3'd1, 1'b0, s, y, q);
        n_vec++;
        if ({y, s[3:0]} !== {4'b0010, 4'd1}) begin
            n_fail++;
            $display("FAIL midflight_next: got y=%b steps=%0d want 0010 1", y, s);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int s; logic [3:0] y; logic [7:0] q;
        do_req(4'b1100, 3'd1, 1'b1, s, y, q);
        n_vec++;
        if (y !== 4'b0110) begin n_fail++; $display("FAIL b2b_first_y: got %b want 0110", y); end
        // Offer the next request in the same cycle the result is consumed.
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_a = 4'b0101;
        in_amt = 3'd0;
        in_dir = 1'b0;
        tick();
        out_ready = 1'b0;
        n_vec++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_no_accept: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if ({out_valid, out_y} !== {1'b1, 4'b0101}) begin
            n_fail++;
            $display("FAIL b2b_second: got vld=%b y=%b want 1 0101", out_valid, out_y);
        end
        consume();
    endtask

    task automatic test_boundaries();
        int s; logic [3:0] y; logic [7:0] q;
        do_req(4'b0001, 3'd7, 1'b0, s, y, q);
        n_vec++;
`ifdef SHIFT_SEQ_ZERO_SKIP_EN
        if ({y, s[3:0]} !== {4'b0000, 4'd2}) begin n_fail++; $display("FAIL amt7_left: got y=%b steps=%0d want 0000 2", y, s); end
`else
        if ({y, s[3:0]} !== {4'b0000, 4'd4}) begin n_fail++; $display("FAIL amt7_left: got y=%b steps=%0d want 0000 4", y, s); end
`endif
        consume();
        do_req(4'b1111, 3'd4, 1'b0, s, y, q);
        n_vec++;
        if ({y, s[3:0]} !== {4'b0000, 4'd2}) begin n_fail++; $display("FAIL amt4_left: got y=%b steps=%0d want 0000 2", y, s); end
        consume();
        do_req(4'b1000, 3'd1, 1'b1, s, y, q);
        n_vec++;
        if ({y, s[3:0], q} !== {4'b0100, 4'd1, 8'b0000_0001}) begin
            n_fail++; $display("FAIL amt1_right: got y=%b steps=%0d seq=%b want 0100 1 00000001", y, s, q);
        end
        consume();
        do_req(4'b1001, 3'd2, 1'b1, s, y, q);
        n_vec++;
        if ({y, s[3:0], q} !== {4'b0010, 4'd1, 8'b0000_0010}) begin
            n_fail++; $display("FAIL amt2_right: got y=%b steps=%0d seq=%b want 0010 1 00000010", y, s, q);
        end
        consume();
        do_req(4'b0000, 3'd6, 1'b0, s, y, q);
        n_vec++;
`ifdef SHIFT_SEQ_ZERO_SKIP_EN
        if ({y, s[3:0]} !== {4'b0000, 4'd0}) begin n_fail++; $display("FAIL zero_operand: got y=%b steps=%0d want 0000 0", y, s); end
`else
        if ({y, s[3:0]} !== {4'b0000, 4'd3}) begin n_fail++; $display("FAIL zero_operand: got y=%b steps=%0d want 0000 3", y, s); end
`endif
        consume();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = 4'h0;
        in_amt = '0;
        in_dir = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_amt3_left();
        test_amt5_right();
        test_amt0();
        test_hold();
        test_reset_midflight();
        test_back_to_back();
        test_boundaries();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
